// File: rtl/bit_packer_if.sv
// rtl/bit_packer_if.sv - AXI-Stream-style channel used on both sides of bit_packer
//
// Purpose: bundles one stream channel (data, valid, ready, last, valid-bit count).
// Parameter W sets the data width; tnbits is sized to hold 0..W.
// Modports:
//   master - drives tdata/tvalid/tlast/tnbits, receives tready
//   slave  - receives tdata/tvalid/tlast, drives tready (bit-serial input has no tnbits)
interface bit_packer_if #(
  parameter int W = 1
);
  logic [W-1:0]             tdata;
  logic                     tvalid;
  logic                     tready;
  logic                     tlast;
  logic [$clog2(W+1)-1:0]   tnbits;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tnbits,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/bit_packer.sv
// rtl/bit_packer.sv - packs a 1-bit interleaver stream into width-bit words
//
// Purpose: collects serial bits into width-bit words, flushes a zero-padded
// partial word on tlast with its valid-bit count, and checks that every block
// carries exactly block_len bits.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset
//   s_axis   - 1-bit input stream (slave): tdata, tvalid, tlast in; tready out
//   m_axis   - width-bit output stream (master): tdata, tvalid, tlast, tnbits out;
//              tready in
//   len_err  - one-cycle pulse when tlast disagrees with the expected block end
module bit_packer #(
  parameter int width     = 8,
  parameter bit msb_first = 1'b1,
  parameter int block_len = 16384
) (
  input  logic            clk,
  input  logic            rst,
  bit_packer_if.slave     s_axis,
  bit_packer_if.master    m_axis,
  output logic            len_err
);

  localparam int BCW = $clog2(width);
  localparam int NBW = $clog2(width + 1);
  localparam int BLW = $clog2(block_len);

  localparam logic [BCW-1:0] LAST_BIT = BCW'(width - 1);
  localparam logic [BLW-1:0] LAST_BLK = BLW'(block_len - 1);

  logic [width-1:0] r_acc;
  logic [BCW-1:0]   r_bcnt;
  logic [BLW-1:0]   r_blk;
  logic [width-1:0] r_m_data;
  logic             r_m_valid;
  logic             r_m_last;
  logic [NBW-1:0]   r_m_nbits;
  logic             r_len_err;

  logic             w_s_ready;
  logic             w_accept;
  logic             w_word_done;
  logic             w_blk_end;
  logic [BCW-1:0]   w_pos;
  logic [width-1:0] w_merged;

  // Ready depends only on the output slot: free, or being drained this cycle.
  assign w_s_ready   = !r_m_valid || m_axis.tready;
  assign w_accept    = s_axis.tvalid && w_s_ready;
  assign w_word_done = w_accept && ((r_bcnt == LAST_BIT) || s_axis.tlast);
  assign w_blk_end   = (r_blk == LAST_BLK);

  // Accumulator with the incoming bit dropped into its slot; unfilled slots stay 0.
  always_comb begin
    w_pos    = msb_first ? (LAST_BIT - r_bcnt) : r_bcnt;
    w_merged = r_acc;
    w_merged[w_pos] = s_axis.tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_bcnt    <= '0;
      r_blk     <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_nbits <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= 1'b0;

      if (r_m_valid && m_axis.tready) begin
        r_m_valid <= 1'b0;
      end

      // A completing word overrides the drain above, giving back-to-back words.
      if (w_accept) begin
        if (w_word_done) begin
          r_m_data  <= w_merged;
          r_m_valid <= 1'b1;
          r_m_last  <= s_axis.tlast;
          r_m_nbits <= NBW'(r_bcnt) + NBW'(1);
          r_acc     <= '0;
          r_bcnt    <= '0;
        end else begin
          r_acc  <= w_merged;
          r_bcnt <= r_bcnt + BCW'(1);
        end

        // Block counter resyncs on either tlast or the expected end; a missing
        // tlast does not flush the word, it only raises the error.
        if (s_axis.tlast || w_blk_end) begin
          r_blk <= '0;
        end else begin
          r_blk <= r_blk + BLW'(1);
        end
        if (s_axis.tlast != w_blk_end) begin
          r_len_err <= 1'b1;
        end
      end
    end
  end

  assign s_axis.tready = w_s_ready;
  assign m_axis.tdata  = r_m_data;
  assign m_axis.tvalid = r_m_valid;
  assign m_axis.tlast  = r_m_last;
  assign m_axis.tnbits = r_m_nbits;
  assign len_err       = r_len_err;

endmodule

// File: tb/tb_bit_packer.sv
// tb/tb_bit_packer.sv - self-checking bench for bit_packer (msb_first=1 and 0 instances)
module tb_bit_packer;

  localparam int W   = 8;
  localparam int BL  = 16;
  localparam int NBW = $clog2(W + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic s_tdata  = 1'b0;
  logic s_tvalid = 1'b0;
  logic s_tlast  = 1'b0;
  logic m_ready  = 1'b1;
  int   rdy_mode = 0;
  logic len_err0;
  logic len_err1;

  bit_packer_if #(.W(1)) s_if0 ();
  bit_packer_if #(.W(1)) s_if1 ();
  bit_packer_if #(.W(W)) m_if0 ();
  bit_packer_if #(.W(W)) m_if1 ();

  assign s_if0.tdata  = s_tdata;
  assign s_if0.tvalid = s_tvalid;
  assign s_if0.tlast  = s_tlast;
  assign s_if0.tnbits = '0;
  assign s_if1.tdata  = s_tdata;
  assign s_if1.tvalid = s_tvalid;
  assign s_if1.tlast  = s_tlast;
  assign s_if1.tnbits = '0;
  assign m_if0.tready = m_ready;
  assign m_if1.tready = m_ready;

  bit_packer #(.width(W), .msb_first(1'b1), .block_len(BL)) dut_msb (
    .clk     (clk),
    .rst     (rst),
    .s_axis  (s_if0),
    .m_axis  (m_if0),
    .len_err (len_err0)
  );

  bit_packer #(.width(W), .msb_first(1'b0), .block_len(BL)) dut_lsb (
    .clk     (clk),
    .rst     (rst),
    .s_axis  (s_if1),
    .m_axis  (m_if1),
    .len_err (len_err1)
  );

  typedef struct {
    logic [W-1:0]   data;
    logic           last;
    logic [NBW-1:0] nbits;
  } word_t;

  word_t        exp_m[$];
  word_t        exp_l[$];
  logic         bit_q[$];
  logic [W-1:0] got_m[$];
  logic [W-1:0] got_l[$];
  int           blk_cnt;
  logic         exp_err;
  logic         hold_prev;
  word_t        prev_w;
  int           n_pulses;
  int           n_stall;
  int           cyc;
  int           n_checks;
  int           n_errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'b0;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference model: bits are collected as a list; a word is emitted when the
  // list reaches W entries or on tlast, with bit k of the word placed at W-1-k
  // (msb instance) or k (lsb instance). Block length is a plain bit count.
  initial begin
    blk_cnt   = 0;
    exp_err   = 1'b0;
    hold_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bit_q.delete();
        exp_m.delete();
        exp_l.delete();
        blk_cnt   = 0;
        exp_err   = 1'b0;
        hold_prev = 1'b0;
      end else begin
        check("len_err_msb", len_err0, exp_err);
        check("len_err_lsb", len_err1, exp_err);
        if (len_err0) n_pulses++;
        if (!s_if0.tready) n_stall++;
        check("s_tready_rule", s_if0.tready, !m_if0.tvalid || m_ready);
        check("tvalid_pair", m_if1.tvalid, m_if0.tvalid);

        if (hold_prev) begin
          check("hold_data", m_if0.tdata, prev_w.data);
          check("hold_last", m_if0.tlast, prev_w.last);
          check("hold_nbits", m_if0.tnbits, prev_w.nbits);
        end

        if (m_if0.tvalid && m_ready) begin
          if (exp_m.size() == 0 || exp_l.size() == 0) begin
            check("unexpected_word", 1, 0);
          end else begin
            word_t em;
            word_t el;
            em = exp_m.pop_front();
            el = exp_l.pop_front();
            check("word_msb_data", m_if0.tdata, em.data);
            check("word_msb_last", m_if0.tlast, em.last);
            check("word_msb_nbits", m_if0.tnbits, em.nbits);
            check("word_lsb_data", m_if1.tdata, el.data);
            check("word_lsb_last", m_if1.tlast, el.last);
            check("word_lsb_nbits", m_if1.tnbits, el.nbits);
          end
          got_m.push_back(m_if0.tdata);
          got_l.push_back(m_if1.tdata);
        end

        hold_prev    = m_if0.tvalid && !m_ready;
        prev_w.data  = m_if0.tdata;
        prev_w.last  = m_if0.tlast;
        prev_w.nbits = m_if0.tnbits;

        exp_err = 1'b0;
        if (s_tvalid && s_if0.tready) begin
          bit_q.push_back(s_tdata);
          exp_err = (s_tlast != (blk_cnt + 1 == BL));
          blk_cnt = (s_tlast || blk_cnt + 1 == BL) ? 0 : blk_cnt + 1;
          if (bit_q.size() == W || s_tlast) begin
            word_t wm;
            word_t wl;
            wm.data = '0;
            wl.data = '0;
            for (int k = 0; k < bit_q.size(); k++) begin
              wm.data[W-1-k] = bit_q[k];
              wl.data[k]     = bit_q[k];
            end
            wm.last  = s_tlast;
            wl.last  = s_tlast;
            wm.nbits = NBW'(bit_q.size());
            wl.nbits = NBW'(bit_q.size());
            exp_m.push_back(wm);
            exp_l.push_back(wl);
            bit_q.delete();
          end
        end
      end
    end
  end

  task automatic send_bit(input logic b, input logic l);
    bit done;
    done     = 1'b0;
    s_tdata  = b;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (s_if0.tready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) check("send_timeout", 0, 1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_vec(input logic [63:0] bits, input int n, input logic last_at_end);
    logic [63:0] v;
    v = bits;
    for (int i = 0; i < n; i++) begin
      send_bit(v[n-1-i], last_at_end && (i == n - 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, m_if0.tvalid, 0);
    check({tag, "_tdata"}, m_if0.tdata, 0);
    check({tag, "_tlast"}, m_if0.tlast, 0);
    check({tag, "_tnbits"}, m_if0.tnbits, 0);
    check({tag, "_len_err"}, len_err0, 0);
    check({tag, "_s_tready"}, s_if0.tready, 1);
    check({tag, "_lsb_tvalid"}, m_if1.tvalid, 0);
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Directed 16-bit block: 0xB2 / 0xF0 (msb), 0x4D / 0x0F (lsb), 1 bit/clk.
    align();
    got_m.delete(); got_l.delete(); n_pulses = 0;
    c0 = cyc;
    send_vec(64'hB2F0, 16, 1'b1);
    check("stream_cycles", cyc - c0, 16);
    repeat (3) @(negedge clk);
    check("t1_count", got_m.size(), 2);
    if (got_m.size() == 2) begin
      check("t1_w0_msb", got_m[0], 8'hB2);
      check("t1_w1_msb", got_m[1], 8'hF0);
      check("t1_w0_lsb", got_l[0], 8'h4D);
      check("t1_w1_lsb", got_l[1], 8'h0F);
    end
    check("t1_pulses", n_pulses, 0);

    // Short block of 11 ones: full word then 3-bit partial, one len_err.
    align();
    got_m.delete(); got_l.delete(); n_pulses = 0;
    send_vec(64'h7FF, 11, 1'b1);
    repeat (3) @(negedge clk);
    check("t3_count", got_m.size(), 2);
    if (got_m.size() == 2) begin
      check("t3_w0", got_m[0], 8'hFF);
      check("t3_w1", got_m[1], 8'hE0);
      check("t3_w1_lsb", got_l[1], 8'h07);
    end
    check("t3_pulses", n_pulses, 1);

    // Missing tlast, then a correct block: one error, four contiguous words.
    align();
    got_m.delete(); got_l.delete(); n_pulses = 0;
    send_vec(64'h1234, 16, 1'b0);
    send_vec(64'hA5C3, 16, 1'b1);
    repeat (3) @(negedge clk);
    check("t4_count", got_m.size(), 4);
    check("t4_pulses", n_pulses, 1);

    // Downstream stall of 20 cycles with a word pending.
    align();
    n_stall = 0;
    send_vec(64'h5A, 7, 1'b0);
    rdy_mode = 1;
    fork
      begin
        send_bit(1'b1, 1'b0);
        send_vec(64'hC6, 8, 1'b1);
      end
      begin
        repeat (20) @(posedge clk);
        rdy_mode = 0;
      end
    join
    repeat (3) @(negedge clk);
    check("t5_stalled", n_stall >= 19, 1);

    // Reset after 5 bits, then a clean block from bit 0.
    align();
    send_vec(64'h1F, 5, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    align();
    got_m.delete(); got_l.delete(); n_pulses = 0;
    send_vec(64'h3C81, 16, 1'b1);
    repeat (3) @(negedge clk);
    check("t6_count", got_m.size(), 2);
    if (got_m.size() == 2) check("t6_w0", got_m[0], 8'h3C);
    check("t6_pulses", n_pulses, 0);

    // Randomized traffic: random data, occasional tlast, random gaps and backpressure.
    align();
    rdy_mode = 2;
    for (int i = 0; i < 500; i++) begin
      send_bit(1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    send_bit(1'b1, 1'b1);
    rdy_mode = 0;
    repeat (10) @(negedge clk);
    check("drain_empty", exp_m.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bit_packer.md
Name: bit_packer

Overview:
- Sits directly downstream of the block interleaver.
- Consumes the interleaver's 1-bit AXI-Stream output, including the end-of-block tlast, and packs the bits into width-bit words for byte- or word-oriented stages such as DMA or a framer.
- A partial final word of a block is zero-padded and flushed, and its valid-bit count is reported.
- Checks that every block carries exactly block_len bits and flags violations.

Parameters:
- width, 8, output word width in bits (2..64).
- msb_first, 1, 1: first received bit goes to m_axis_tdata[width-1]; 0: first bit goes to m_axis_tdata[0].
- block_len, 16384, expected bits per interleaver block (row*col); must be >= 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- s_axis_tdata  input  1  serial input bit.
- s_axis_tvalid  input  1  input bit valid.
- s_axis_tlast  input  1  last bit of the block.
- s_axis_tready  output  1  input accept.
- m_axis_tdata  output  width  packed word.
- m_axis_tvalid  output  1  word valid.
- m_axis_tlast  output  1  word contains the block's last bit.
- m_axis_tnbits  output  $clog2(width+1)  number of valid bits in the word: width for full words, 1..width on a tlast word.
- m_axis_tready  input  1  downstream accept.
- len_err  output  1  one-cycle pulse on a block-length mismatch.

Behaviour:
- Reset (rst=1 at a clk edge): all state clears. Outputs after reset: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tnbits=0, len_err=0, s_axis_tready=1. Reset mid-block discards the partial word and the pending output word with no flush.
- Input handshake: bit accepted when s_axis_tvalid && s_axis_tready. s_axis_tready = !m_axis_tvalid || m_axis_tready. This is combinational from m_axis_tready and does not depend on s_axis_tvalid.
- Accumulator: shift register acc[width-1:0] plus bit counter bcnt (0..width-1).
  - msb_first=1: word bit index for the k-th bit of a word (k=0..) is width-1-k.
  - msb_first=0: word bit index is k.
  - Unfilled positions are 0.
- Word completion happens on an accepted bit when bcnt==width-1 or s_axis_tlast=1. On completion, at the next edge:
  - m_axis_tdata = acc merged with the current bit.
  - m_axis_tvalid = 1.
  - m_axis_tlast = s_axis_tlast.
  - m_axis_tnbits = bcnt+1.
  - acc and bcnt clear to 0.
- Non-completing accepted bit: acc updated, bcnt+1; the output register is unchanged.
- Output register:
  - Holds its value while m_axis_tvalid && !m_axis_tready.
  - Clears m_axis_tvalid on m_axis_tready unless a new word completes in the same cycle. Simultaneous drain and completion loads the new word with m_axis_tvalid staying 1 (back-to-back).
- Latency: last bit of a word accepted at edge N gives m_axis_tvalid=1 after edge N. Sustained throughput is 1 bit/clk with no bubbles when m_axis_tready=1.
- Boundary cases:
  - tlast with bcnt==width-1 gives a full word with tlast=1 and tnbits=width.
  - tlast on the first bit of a word gives tnbits=1.
  - A block shorter than width gives a single partial word.
- Block length check: counter blk (0..block_len-1) increments on each accepted bit.
  - On an accepted bit with s_axis_tlast=1 or blk==block_len-1, blk returns to 0.
  - If s_axis_tlast != (blk==block_len-1) on that bit, len_err=1 for exactly one cycle after that edge.
  - A missing tlast does not force a word flush; packing continues uninterrupted.
  - Data always passes regardless of len_err.
- Input bits presented while s_axis_tready=0 are not consumed; the upstream must hold them.

Test Plan:
(Configuration: width=8, msb_first=1, block_len=16 unless stated.)
- Reset then stream 16 bits 1,0,1,1,0,0,1,0, 1,1,1,1,0,0,0,0 (tlast on bit 16), m_axis_tready=1 -> words 0xB2 (tlast=0, tnbits=8) then 0xF0 (tlast=1, tnbits=8); len_err stays 0; no input stall.
- Same stream with msb_first=0 -> words 0x4D then 0x0F.
- Block of 11 bits, all 1, tlast on bit 11 -> 0xFF (tnbits=8), then 0xE0 (tlast=1, tnbits=3); len_err pulses one cycle after the tlast bit.
- 16 bits with no tlast followed by a 16-bit block with correct tlast -> len_err pulses once, after bit 16; the second block raises no error; word stream is contiguous (4 words).
- Hold m_axis_tready=0 for 20 cycles mid-stream while a word is pending -> s_axis_tready=0; the word is held stable with no loss or duplication. Release -> resumes at 1 bit/clk.
- Assert rst for 1 cycle after 5 bits of a block -> all outputs at reset values. A following clean 16-bit block packs from bit 0 with no len_err.
